// File: rtl/counter_wrap_monitor_if.sv
// Bundle between the up/down counter side and counter_wrap_monitor.
// The master drives the counter's observed controls and outputs and reads the
// monitor's events. The slave is the monitor itself.
// The monitor is passive: there is no valid/ready handshake, and every signal is sampled on each clk edge.
interface counter_wrap_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int PER_W = 16
);
    // observed counter controls and outputs
    logic             cnt_rst_n;
    logic             load_n;
    logic             up_down;
    logic             ce;
    logic [WIDTH-1:0] count_out;
    logic             max_count;
    logic             zero;
    logic             clr_err;
    // monitor results
    logic             wrap_up;
    logic             wrap_down;
    logic [CNT_W-1:0] wrap_cnt;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             err_flag;
    logic [2:0]       err_code;

    modport master (
        output cnt_rst_n, load_n, up_down, ce, count_out, max_count, zero, clr_err,
        input  wrap_up, wrap_down, wrap_cnt, period, period_valid, err_flag, err_code
    );

    modport slave (
        input  cnt_rst_n, load_n, up_down, ce, count_out, max_count, zero, clr_err,
        output wrap_up, wrap_down, wrap_cnt, period, period_valid, err_flag, err_code
    );
endinterface

// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor: passive checker that sits behind an up/down counter.
// It reports up-wraps and down-wraps, a running wrap count, and the clock period between wraps.
// It keeps sticky error flags for flag and step inconsistencies.
// Every result is registered and lags the observed count_out by one clock.
// Optional macro COUNTER_MON_STEP_CHECK_EN builds the +/-1 step checker that drives err_code[2].
// Without the macro, err_code[2] is tied to 0.
module counter_wrap_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int PER_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    counter_wrap_monitor_if.slave bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [PER_W-1:0] PER_MAX  = '1;

    // previous-cycle snapshot of the counter
    logic [WIDTH-1:0] prev_count;
    logic             prev_inc;
    logic             prev_dec;
    logic             prev_valid;
    logic             prev_rst_low;   // counter was held in reset last cycle

    // period measurement state
    logic [PER_W-1:0] acc;
    logic             seen_wrap;

    // registered outputs
    logic             wrap_up_q;
    logic             wrap_down_q;
    logic [CNT_W-1:0] wrap_cnt_q;
    logic [PER_W-1:0] period_q;
    logic             period_valid_q;
    logic             err_flag_q;
    logic [2:0]       err_code_q;

    // combinational detection for the current cycle
    logic             flag_en;
    logic             step_en;
    logic             max_err;
    logic             zero_err;
    logic             step_err;
    logic             wrap_up_d;
    logic             wrap_down_d;
    logic             wrap_any;
    logic [PER_W-1:0] acc_inc;
    logic [2:0]       code_next;

    // Flag checks pause while the counter is in reset and for one cycle after it.
    // Step checks and wrap checks also require a valid previous sample.
    assign flag_en  = bus.cnt_rst_n & ~prev_rst_low;
    assign step_en  = bus.cnt_rst_n & prev_valid;

    assign max_err  = flag_en & (bus.max_count != (bus.count_out == ALL_ONES));
    assign zero_err = flag_en & (bus.zero != (bus.count_out == ALL_ZERO));

    // A load or hold last cycle clears prev_inc and prev_dec, so no wrap is seen across a load.
    assign wrap_up_d   = step_en & prev_inc & (prev_count == ALL_ONES) & (bus.count_out == ALL_ZERO);
    assign wrap_down_d = step_en & prev_dec & (prev_count == ALL_ZERO) & (bus.count_out == ALL_ONES);
    assign wrap_any    = wrap_up_d | wrap_down_d;

`ifdef COUNTER_MON_STEP_CHECK_EN
    logic [WIDTH-1:0] exp_up;
    logic [WIDTH-1:0] exp_down;
    assign exp_up   = prev_count + WIDTH'(1);
    assign exp_down = prev_count - WIDTH'(1);
    assign step_err = step_en & ((prev_inc & (bus.count_out != exp_up)) |
                                 (prev_dec & (bus.count_out != exp_down)));
`else
    assign step_err = 1'b0;
`endif

    assign acc_inc   = (acc == PER_MAX) ? acc : acc + PER_W'(1);
    // Clearing drops the old bits, but an error detected in the same cycle is still set.
    assign code_next = (bus.clr_err ? 3'b000 : err_code_q) | {step_err, zero_err, max_err};

    // capture the counter's state for next cycle's step and wrap qualification
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_count   <= '0;
            prev_inc     <= 1'b0;
            prev_dec     <= 1'b0;
            prev_valid   <= 1'b0;
            prev_rst_low <= 1'b0;
        end else begin
            prev_count   <= bus.count_out;
            prev_inc     <= bus.ce & bus.load_n & bus.cnt_rst_n & bus.up_down;
            prev_dec     <= bus.ce & bus.load_n & bus.cnt_rst_n & ~bus.up_down;
            prev_valid   <= bus.cnt_rst_n;
            prev_rst_low <= ~bus.cnt_rst_n;
        end
    end

    // wrap pulses and the rolling wrap counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
            wrap_cnt_q  <= '0;
        end else begin
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
            if (wrap_any) begin
                wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
            end
        end
    end

    // period between consecutive wraps. The first wrap after reset only arms the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc            <= '0;
            seen_wrap      <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= wrap_any & seen_wrap;
            if (wrap_any) begin
                acc       <= '0;
                seen_wrap <= 1'b1;
                if (seen_wrap) begin
                    period_q <= acc_inc;
                end
            end else begin
                acc <= acc_inc;
            end
        end
    end

    // sticky error accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            err_code_q <= 3'b000;
            err_flag_q <= 1'b0;
        end else begin
            err_code_q <= code_next;
            err_flag_q <= |code_next;
        end
    end

    assign bus.wrap_up      = wrap_up_q;
    assign bus.wrap_down    = wrap_down_q;
    assign bus.wrap_cnt     = wrap_cnt_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.err_flag     = err_flag_q;
    assign bus.err_code     = err_code_q;
endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Self-checking bench for counter_wrap_monitor (WIDTH=4).
// The bench acts as the counter, choosing one action per cycle, and injects flag and step faults.
// A reference model derives the expected outputs from the sample history.
module tb_counter_wrap_monitor;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int PER_W = 16;

  typedef enum int {A_UP, A_DOWN, A_HOLD, A_LOAD, A_CRST} act_t;

  logic clk;
  logic rst;

  counter_wrap_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PER_W(PER_W)) bus ();

  counter_wrap_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // counter state played by the bench
  logic [3:0] cnt = 4'h0;

  // reference model state
  bit         p_exists = 0;
  act_t       p_act = A_HOLD;
  logic [3:0] p_cnt = 4'h0;
  int         idx = 0;
  int         last_wrap = 0;
  bit         seen = 0;
  logic       e_wu = 1'b0;
  logic       e_wd = 1'b0;
  logic [7:0] e_wcnt = 8'h0;
  logic [15:0] e_per = 16'h0;
  logic       e_pv = 1'b0;
  logic [2:0] e_code = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at sample %0d: got %0h expected %0h", tag, idx, got, exp);
  endtask

  // model one sample: rules stated in terms of what the counter did
  task automatic model_sample(input act_t a, input logic [3:0] c, input logic mx, input logic zr,
                              input bit clr, input bit do_rst);
    bit cur_crst, fchk, wu, wd, se;
    logic [3:0] nxt_up, nxt_dn;
    int diff;
    if (do_rst) begin
      e_wu = 0; e_wd = 0; e_wcnt = 0; e_per = 0; e_pv = 0; e_code = 0;
      seen = 0; p_exists = 0;
      idx++;
      return;
    end
    cur_crst = (a == A_CRST);
    nxt_up = p_cnt + 4'd1;
    nxt_dn = p_cnt - 4'd1;
    wu = p_exists && !cur_crst && p_act == A_UP   && p_cnt == 4'hF && c == 4'h0;
    wd = p_exists && !cur_crst && p_act == A_DOWN && p_cnt == 4'h0 && c == 4'hF;
    se = 0;
`ifdef COUNTER_MON_STEP_CHECK_EN
    se = p_exists && !cur_crst && ((p_act == A_UP && c != nxt_up) || (p_act == A_DOWN && c != nxt_dn));
`endif
    fchk = !cur_crst && !(p_exists && p_act == A_CRST);
    e_code = (clr ? 3'b000 : e_code) |
             {se, fchk && (zr != (c == 4'h0)), fchk && (mx != (c == 4'hF))};
    e_wu = wu;
    e_wd = wd;
    e_pv = 0;
    if (wu || wd) begin
      e_wcnt = e_wcnt + 8'd1;
      if (seen) begin
        diff = idx - last_wrap;
        e_per = (diff > 65535) ? 16'hFFFF : 16'(diff);
        e_pv = 1;
      end
      last_wrap = idx;
      seen = 1;
    end
    p_exists = 1;
    p_act = a;
    p_cnt = c;
    idx++;
  endtask

  // driver: present one counter cycle, advance the counter, then compare outputs
  task automatic drive_cycle(input act_t a, input logic [3:0] ldv, input bit clr,
                             input bit [1:0] ff, input bit sf, input bit do_rst);
    logic [3:0] c;
    logic mx, zr;
    @(negedge clk);
    c  = cnt;
    mx = (c == 4'hF) ^ ff[0];
    zr = (c == 4'h0) ^ ff[1];
    bus.count_out = c;
    bus.max_count = mx;
    bus.zero      = zr;
    bus.cnt_rst_n = (a != A_CRST);
    bus.load_n    = (a != A_LOAD);
    bus.ce        = (a == A_UP || a == A_DOWN || a == A_LOAD) ? 1'b1 :
                    (a == A_HOLD) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.up_down   = (a == A_UP) ? 1'b1 : (a == A_DOWN) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.clr_err   = clr;
    rst           = do_rst;
    model_sample(a, c, mx, zr, clr, do_rst);
    case (a)
      A_UP:    cnt = sf ? c + 4'd2 : c + 4'd1;
      A_DOWN:  cnt = sf ? c - 4'd2 : c - 4'd1;
      A_LOAD:  cnt = ldv;
      A_CRST:  cnt = 4'h0;
      default: cnt = c;
    endcase
    @(posedge clk);
    #1;
    check("wrap_up",      32'(bus.wrap_up),      32'(e_wu));
    check("wrap_down",    32'(bus.wrap_down),    32'(e_wd));
    check("wrap_cnt",     32'(bus.wrap_cnt),     32'(e_wcnt));
    check("period",       32'(bus.period),       32'(e_per));
    check("period_valid", 32'(bus.period_valid), 32'(e_pv));
    check("err_code",     32'(bus.err_code),     32'(e_code));
    check("err_flag",     32'(bus.err_flag),     32'(|e_code));
  endtask

  task automatic run(input act_t a, input int n);
    for (int i = 0; i < n; i++) drive_cycle(a, 4'h0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    int r;
    act_t a;
    rst = 1'b1;
    bus.cnt_rst_n = 1'b1; bus.load_n = 1'b1; bus.up_down = 1'b1; bus.ce = 1'b0;
    bus.count_out = '0; bus.max_count = 1'b0; bus.zero = 1'b1; bus.clr_err = 1'b0;

    // reset, then count up through one wrap
    for (int i = 0; i < 3; i++) drive_cycle(A_HOLD, 4'h0, 0, 2'b00, 0, 1);
    run(A_UP, 20);
    // count down through zero twice
    run(A_DOWN, 34);
    // load F then count up into 0; then a load from F to 0 must not wrap
    drive_cycle(A_LOAD, 4'hF, 0, 2'b00, 0, 0);
    run(A_UP, 3);
    drive_cycle(A_LOAD, 4'hF, 0, 2'b00, 0, 0);
    drive_cycle(A_LOAD, 4'h0, 0, 2'b00, 0, 0);
    run(A_HOLD, 2);
    // max_count forced low at F; sticky until clr_err
    drive_cycle(A_LOAD, 4'hF, 0, 2'b00, 0, 0);
    drive_cycle(A_HOLD, 4'h0, 0, 2'b01, 0, 0);
    run(A_HOLD, 3);
    drive_cycle(A_HOLD, 4'h0, 1, 2'b00, 0, 0);
    run(A_HOLD, 2);
    // clear and a new error in the same cycle: the new error wins
    drive_cycle(A_HOLD, 4'h0, 1, 2'b10, 0, 0);
    drive_cycle(A_HOLD, 4'h0, 1, 2'b00, 0, 0);
    // step jump 3 -> 5 while counting up
    drive_cycle(A_LOAD, 4'h3, 0, 2'b00, 0, 0);
    drive_cycle(A_UP,   4'h0, 0, 2'b00, 1, 0);
    run(A_HOLD, 2);
    drive_cycle(A_HOLD, 4'h0, 1, 2'b00, 0, 0);
    // counter reset while at F, then the counter reads 0
    drive_cycle(A_LOAD, 4'hF, 0, 2'b00, 0, 0);
    drive_cycle(A_UP,   4'h0, 0, 2'b00, 0, 0);
    drive_cycle(A_LOAD, 4'hF, 0, 2'b00, 0, 0);
    drive_cycle(A_CRST, 4'h0, 0, 2'b00, 0, 0);
    run(A_UP, 3);
    // rst dominates clr_err and a fresh flag fault
    drive_cycle(A_LOAD, 4'hF, 0, 2'b00, 0, 0);
    drive_cycle(A_HOLD, 4'h0, 0, 2'b01, 0, 0);
    drive_cycle(A_HOLD, 4'h0, 1, 2'b01, 0, 1);
    run(A_UP, 18);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      a = (r < 40) ? A_UP : (r < 72) ? A_DOWN : (r < 84) ? A_HOLD : (r < 95) ? A_LOAD : A_CRST;
      drive_cycle(a, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 3)) : 2'b00,
                  ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 999) < 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
